pt_feeder: RTL and testbench

PT_FEEDER -- requirements
Module: pt_feeder

---
 rtl/conv_pkg.sv | 27 ++
 rtl/pt_fifo.sv | 54 +++++
 rtl/pt_feeder.sv | 96 +++++++++
 tb/tb_pt_feeder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared point type and serialization constants for the point feeder.
// Used by pt_fifo and pt_feeder.
package conv_pkg;

  localparam int COORD_W = 10;
  localparam int SLICE_W = 5;
  localparam int NSLICE  = 4;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  // Slice counter counts down 4..1; 0 means nothing is being serialized
  function automatic logic [SLICE_W-1:0] slice_of(point_t p, logic [2:0] cnt);
    logic [SLICE_W-1:0] s;
    case (cnt)
      3'd4:    s = p.x[COORD_W-1:SLICE_W];
      3'd3:    s = p.x[SLICE_W-1:0];
      3'd2:    s = p.y[COORD_W-1:SLICE_W];
      3'd1:    s = p.y[SLICE_W-1:0];
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pt_fifo.sv
// Synchronous point FIFO with full/empty flags and a combinational head read.
// Pointers carry one extra wrap bit to tell full from empty.
module pt_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  logic   pop_i,
  input  point_t wdata_i,
  output point_t rdata_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);

  point_t        mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Storage is not reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/pt_feeder.sv
// Buffers host points and serializes each as four 5-bit slices to the core.
// Optional drop logging is enabled with `define PT_FEEDER_DROPLOG_EN.
module pt_feeder
  import conv_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               LD_V,
  input  logic [COORD_W-1:0] LD_X,
  input  logic [COORD_W-1:0] LD_Y,
  output logic               LD_RDY,
  input  logic               READ_PT,
  output logic [SLICE_W-1:0] PT_XY,
  output logic               BUSY,
  output logic               EMPTY,
  output logic [7:0]         PT_CNT,
  input  logic               DROP_V,
  input  logic [COORD_W-1:0] DROP_X,
  input  logic [COORD_W-1:0] DROP_Y,
  output logic [7:0]         DROP_CNT
);

  point_t     head;
  point_t     out_q;
  logic       fifo_full, fifo_empty;
  logic       pop_go;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] pt_cnt_q;

  // A new point may start on the last slice of the current one, so there is no gap
  assign pop_go = READ_PT && (cnt_q <= 3'd1) && !fifo_empty;

  pt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .push_i  (LD_V),
    .pop_i   (pop_go),
    .wdata_i ('{x: LD_X, y: LD_Y}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (pop_go)              cnt_d = 3'(NSLICE);
    else if (cnt_q != 3'd0)  cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q    <= '0;
      out_q    <= '0;
      pt_cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (pop_go) begin
        out_q    <= head;
        pt_cnt_q <= pt_cnt_q + 8'd1;
      end
    end
  end

  assign PT_XY  = slice_of(out_q, cnt_q);
  assign BUSY   = (cnt_q != 3'd0);
  assign EMPTY  = fifo_empty;
  assign LD_RDY = !fifo_full;
  assign PT_CNT = pt_cnt_q;

`ifdef PT_FEEDER_DROPLOG_EN
  logic [7:0] drop_cnt_q;
  point_t     last_drop_q;
  logic       drop_unused;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      drop_cnt_q  <= '0;
      last_drop_q <= '0;
    end else if (DROP_V) begin
      if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      last_drop_q <= '{x: DROP_X, y: DROP_Y};
    end
  end

  // Last drop is kept only for debug probing
  assign drop_unused = ^last_drop_q;
  assign DROP_CNT    = drop_cnt_q;
`else
  logic drop_unused;
  assign drop_unused = ^{DROP_V, DROP_X, DROP_Y};
  assign DROP_CNT    = 8'd0;
`endif

endmodule

// File: tb/tb_pt_feeder.sv
// Directed bench for pt_feeder: vector table plus full-FIFO, reset and drop sequences.
module tb_pt_feeder;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       LD_V;
  logic [9:0] LD_X, LD_Y;
  logic       LD_RDY;
  logic       READ_PT;
  logic [4:0] PT_XY;
  logic       BUSY, EMPTY;
  logic [7:0] PT_CNT;
  logic       DROP_V;
  logic [9:0] DROP_X, DROP_Y;
  logic [7:0] DROP_CNT;

  int errors = 0;
  int checks = 0;

`ifdef PT_FEEDER_DROPLOG_EN
  localparam bit DROPLOG = 1'b1;
`else
  localparam bit DROPLOG = 1'b0;
`endif

  always #5 CLK = ~CLK;

  pt_feeder #(.DEPTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .LD_V(LD_V), .LD_X(LD_X), .LD_Y(LD_Y),
    .LD_RDY(LD_RDY), .READ_PT(READ_PT), .PT_XY(PT_XY), .BUSY(BUSY),
    .EMPTY(EMPTY), .PT_CNT(PT_CNT), .DROP_V(DROP_V), .DROP_X(DROP_X),
    .DROP_Y(DROP_Y), .DROP_CNT(DROP_CNT)
  );

  typedef struct {
    logic       ld_v;
    logic [9:0] ld_x;
    logic [9:0] ld_y;
    logic       rd;
    logic [4:0] xy;
    logic       busy;
    logic       empty;
    logic       rdy;
    logic [7:0] ptc;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mk(logic ld_v, int x, int y, logic rd, int xy,
                              logic busy, logic empty, logic rdy, int ptc);
    vec_t v;
    v.ld_v = ld_v; v.ld_x = 10'(x); v.ld_y = 10'(y); v.rd = rd;
    v.xy = 5'(xy); v.busy = busy; v.empty = empty; v.rdy = rdy; v.ptc = 8'(ptc);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; LD_V = 1'b0; READ_PT = 1'b0; DROP_V = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  function automatic int slice_ref(int x, int y, int s);
    case (s)
      0: return (x / 32) % 32;
      1: return x % 32;
      2: return (y / 32) % 32;
      default: return y % 32;
    endcase
  endfunction

  int px [16];
  int py [16];

  initial begin
    RST_N = 1'b0; LD_V = 1'b0; LD_X = '0; LD_Y = '0; READ_PT = 1'b0;
    DROP_V = 1'b0; DROP_X = '0; DROP_Y = '0;

    // Single point (100,200), then back-to-back (100,200),(1023,0), then empty requests
    vecs[0]  = mk(1, 100, 200, 1,  0, 0, 0, 1, 0);
    vecs[1]  = mk(0,   0,   0, 1,  3, 1, 1, 1, 1);
    vecs[2]  = mk(0,   0,   0, 1,  4, 1, 1, 1, 1);
    vecs[3]  = mk(0,   0,   0, 1,  6, 1, 1, 1, 1);
    vecs[4]  = mk(0,   0,   0, 1,  8, 1, 1, 1, 1);
    vecs[5]  = mk(0,   0,   0, 1,  0, 0, 1, 1, 1);
    vecs[6]  = mk(1, 100, 200, 0,  0, 0, 0, 1, 1);
    vecs[7]  = mk(1,1023,   0, 1,  3, 1, 0, 1, 2);
    vecs[8]  = mk(0,   0,   0, 1,  4, 1, 0, 1, 2);
    vecs[9]  = mk(0,   0,   0, 1,  6, 1, 0, 1, 2);
    vecs[10] = mk(0,   0,   0, 1,  8, 1, 0, 1, 2);
    vecs[11] = mk(0,   0,   0, 1, 31, 1, 1, 1, 3);
    vecs[12] = mk(0,   0,   0, 1, 31, 1, 1, 1, 3);
    vecs[13] = mk(0,   0,   0, 1,  0, 1, 1, 1, 3);
    vecs[14] = mk(0,   0,   0, 1,  0, 1, 1, 1, 3);
    vecs[15] = mk(0,   0,   0, 1,  0, 0, 1, 1, 3);
    for (int i = 16; i < 21; i++) vecs[i] = mk(0, 0, 0, 1, 0, 0, 1, 1, 3);
    vecs[21] = mk(1, 640,  33, 1,  0, 0, 0, 1, 3);
    vecs[22] = mk(0,   0,   0, 1, 20, 1, 1, 1, 4);
    vecs[23] = mk(0,   0,   0, 0,  0, 1, 1, 1, 4);
    vecs[24] = mk(0,   0,   0, 0,  1, 1, 1, 1, 4);
    vecs[25] = mk(0,   0,   0, 0,  1, 1, 1, 1, 4);
    vecs[26] = mk(0,   0,   0, 0,  0, 0, 1, 1, 4);

    #12;
    check("rst_pt_xy", PT_XY, 0);
    check("rst_busy", BUSY, 0);
    check("rst_empty", EMPTY, 1);
    check("rst_ld_rdy", LD_RDY, 1);
    check("rst_pt_cnt", PT_CNT, 0);
    check("rst_drop_cnt", DROP_CNT, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 27; i++) begin
      LD_V = vecs[i].ld_v; LD_X = vecs[i].ld_x; LD_Y = vecs[i].ld_y;
      READ_PT = vecs[i].rd;
      step();
      $display("vec %0d: xy=%0d busy=%0b empty=%0b rdy=%0b ptc=%0d",
               i, PT_XY, BUSY, EMPTY, LD_RDY, PT_CNT);
      check($sformatf("vec%0d_xy", i), PT_XY, vecs[i].xy);
      check($sformatf("vec%0d_busy", i), BUSY, vecs[i].busy);
      check($sformatf("vec%0d_empty", i), EMPTY, vecs[i].empty);
      check($sformatf("vec%0d_rdy", i), LD_RDY, vecs[i].rdy);
      check($sformatf("vec%0d_ptc", i), PT_CNT, vecs[i].ptc);
    end

    // Fill to 16, try a 17th, then drain everything in order
    do_reset();
    for (int i = 0; i < 16; i++) begin
      px[i] = (i * 37 + 1) % 1024;
      py[i] = (i * 11 + 500) % 1024;
      LD_V = 1'b1; LD_X = 10'(px[i]); LD_Y = 10'(py[i]);
      step();
    end
    check("full_ld_rdy", LD_RDY, 0);
    LD_X = 10'd999; LD_Y = 10'd999;
    step();
    LD_V = 1'b0;
    check("full17_ld_rdy", LD_RDY, 0);
    check("full17_empty", EMPTY, 0);
    READ_PT = 1'b1;
    for (int k = 0; k < 16; k++) begin
      for (int s = 0; s < 4; s++) begin
        step();
        if (k == 0 && s == 0) check("pop1_ld_rdy", LD_RDY, 1);
        check($sformatf("drain_p%0d_s%0d", k, s), PT_XY, slice_ref(px[k], py[k], s));
      end
      $display("drain point %0d: (%0d,%0d) ptc=%0d", k, px[k], py[k], PT_CNT);
    end
    READ_PT = 1'b0;
    step();
    check("drain_empty", EMPTY, 1);
    check("drain_busy", BUSY, 0);
    check("drain_ptc", PT_CNT, 16);

    // Asynchronous reset after the second slice aborts the point
    LD_V = 1'b1; LD_X = 10'd100; LD_Y = 10'd200;
    step();
    LD_V = 1'b0; READ_PT = 1'b1;
    step();
    step();
    check("pre_rst_xy", PT_XY, 4);
    #2 RST_N = 1'b0;
    #1;
    $display("async reset: xy=%0d busy=%0b empty=%0b ptc=%0d", PT_XY, BUSY, EMPTY, PT_CNT);
    check("arst_xy", PT_XY, 0);
    check("arst_busy", BUSY, 0);
    check("arst_empty", EMPTY, 1);
    check("arst_ptc", PT_CNT, 0);
    check("arst_ld_rdy", LD_RDY, 1);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    step();
    check("no_reissue_xy", PT_XY, 0);
    check("no_reissue_ptc", PT_CNT, 0);
    READ_PT = 1'b0;

    // Drop counter: three pulses, then saturation
    DROP_X = 10'd7; DROP_Y = 10'd9;
    for (int i = 0; i < 3; i++) begin
      DROP_V = 1'b1; step();
      DROP_V = 1'b0; step();
    end
    $display("drops after 3: %0d", DROP_CNT);
    check("drop3", DROP_CNT, DROPLOG ? 3 : 0);
    DROP_V = 1'b1;
    for (int i = 0; i < 297; i++) step();
    DROP_V = 1'b0;
    step();
    $display("drops after 300: %0d", DROP_CNT);
    check("drop300", DROP_CNT, DROPLOG ? 255 : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
